lcd_msg_writer: RTL
===================

LCD_MSG_WRITER -- requirements
Module: lcd_msg_writer

Interface
REQ-001 SHALL have parameter T_PWRUP, 375000, power-up wait in CLK cycles (15 ms at 25 MHz).
REQ-002 SHALL have parameter T_EN, 12, LCD_EN high width in cycles.
REQ-003 SHALL have parameter T_CMD, 1000, post-write hold for all writes except clear.
REQ-004 SHALL have parameter T_CLR, 41000, post-write hold after clear (0x01).
REQ-005 SHALL have port CLK  in  1  sole clock; all logic on posedge.
REQ-006 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port message_i  in  489 ([61*8:0])  text; byte i = bits [8i+7:8i]; first char at byte length_i-1.
REQ-008 SHALL have port length_i  in  9  valid character count.
REQ-009 SHALL have port LCD_DATA  out  8  HD44780 data bus.
REQ-010 SHALL have ports LCD_RS, LCD_RW, LCD_EN, LCD_ON  out  1 each  register select, read/write (tied 0), enable strobe, backlight/power.
REQ-011 SHALL have port busy_o  out  1  high while initialising or refreshing.

Function
REQ-012 SHALL use one write sub-sequence per byte: drive RS/DATA with EN=0 for 2 cycles; EN=1 for T_EN cycles; EN=0; hold T_CMD (T_CLR after 0x01) cycles; DATA/RS stable throughout.
REQ-013 SHALL use FSM states PWRUP, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2.
REQ-014 PWRUP SHALL count T_PWRUP cycles, then go to INIT.
REQ-015 INIT SHALL write commands (RS=0) 0x38, 0x0C, 0x06, 0x01 in order, then go to IDLE.
REQ-016 IDLE SHALL start a refresh when {message_i,length_i} differs from the internal snapshot; the snapshot is loaded at refresh start.
REQ-017 A refresh SHALL write 0x80 (ADDR1), 16 chars (LINE1), 0xC0 (ADDR2), 16 chars (LINE2), i.e. 34 writes, then return to IDLE.
REQ-018 Display position p (0..31) SHALL show snapshot byte (len-1-p) if p < len, else 0x20.
REQ-019 len SHALL be min(length_i, 61); chars beyond position 31 SHALL NOT be shown.
REQ-020 Bytes <0x20 or >0x7E SHALL be written as 0x20.
REQ-021 Input changes during a refresh SHALL NOT alter it; the mismatch SHALL trigger a new refresh on return to IDLE.
REQ-022 busy_o SHALL be 0 only in IDLE with no pending mismatch.
REQ-023 LCD_RW SHALL be 0 always; LCD_ON SHALL be 1 whenever RESET is high.

Reset
REQ-024 RESET low SHALL force LCD_DATA=0, LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_ON=0, busy_o=1, counters and snapshot=0, state PWRUP.
REQ-025 RESET assertion mid-write SHALL drop LCD_EN immediately; the full power-up and init sequence SHALL rerun after release.
REQ-026 The first refresh after init SHALL occur only if the inputs differ from the zero snapshot.

Configuration
REQ-027 With LCD_UPCASE_EN defined, bytes 0x61-0x7A SHALL be written minus 0x20 (after REQ-020 filtering).
REQ-028 Without LCD_UPCASE_EN, printable bytes SHALL be written unchanged.

Verification (T_PWRUP=20, T_EN=2, T_CMD=4, T_CLR=8)
REQ-029 Release reset, inputs 0 -> 4 EN pulses with DATA 0x38, 0x0C, 0x06, 0x01, RS=0; then busy_o=0, no further pulses.
REQ-030 length_i=2, bytes[1:0]="hi" (0x68,0x69) -> 34 writes: 0x80, 'h', 'i', 14x0x20, 0xC0, 16x0x20; RS=1 on characters only.
REQ-031 length_i=40 -> exactly 32 characters, bytes 39 down to 8; byte 7 never written.
REQ-032 message byte 0x0A at position 0 -> 0x20 written; with LCD_UPCASE_EN, 'a' -> 0x41, without -> 0x61.
REQ-033 Change length_i during the 10th write -> refresh completes unchanged, then a second 34-write refresh with the new text.
REQ-034 Assert RESET while LCD_EN=1 -> all outputs at reset values in the same cycle; after release, PWRUP wait then init rerun.

Source files
------------

// File: rtl/lcd_msg_writer.sv
// lcd_msg_writer: HD44780 8-bit bus driver that powers up, initialises and
// mirrors a byte string onto a 2x16 display. Define LCD_UPCASE_EN to upcase.
module lcd_msg_writer #(
    parameter int T_PWRUP = 375000,
    parameter int T_EN    = 12,
    parameter int T_CMD   = 1000,
    parameter int T_CLR   = 41000
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [488:0] message_i,
    input  logic [8:0]   length_i,
    output logic [7:0]   LCD_DATA,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_EN,
    output logic         LCD_ON,
    output logic         busy_o
);

    localparam logic [2:0] PWRUP = 3'd0;
    localparam logic [2:0] INIT  = 3'd1;
    localparam logic [2:0] IDLE  = 3'd2;
    localparam logic [2:0] ADDR1 = 3'd3;
    localparam logic [2:0] LINE1 = 3'd4;
    localparam logic [2:0] ADDR2 = 3'd5;
    localparam logic [2:0] LINE2 = 3'd6;

    localparam logic [1:0] WR_IDLE  = 2'd0;
    localparam logic [1:0] WR_SETUP = 2'd1;
    localparam logic [1:0] WR_PULSE = 2'd2;
    localparam logic [1:0] WR_HOLD  = 2'd3;

    logic [2:0]   state;
    logic [3:0]   idx;
    logic [31:0]  pwr_cnt;
    logic [1:0]   phase;
    logic [31:0]  wr_cnt;
    logic [488:0] snap_msg;
    logic [8:0]   snap_len;

    logic         pending;
    logic [5:0]   len_eff;
    logic [4:0]   pos;
    logic         in_text;
    logic [5:0]   sel;
    logic [7:0]   raw;
    logic [7:0]   flt;
    logic [7:0]   chr;
    logic [7:0]   wr_byte;
    logic         wr_rs;
    logic         wr_start;
    logic         wr_done;
    logic [31:0]  hold_len;

    assign pending = {message_i, length_i} != {snap_msg, snap_len};
    assign busy_o  = !((state == IDLE) && !pending);
    assign LCD_RW  = 1'b0;
    assign LCD_ON  = RESET;

    // Display position to snapshot byte: first character sits at byte len-1.
    always_comb begin
        len_eff = (snap_len > 9'd61) ? 6'd61 : snap_len[5:0];
        pos     = {state == LINE2, idx};
        in_text = {1'b0, pos} < len_eff;
        sel     = len_eff - 6'd1 - {1'b0, pos};
        raw     = snap_msg[{sel, 3'b000} +: 8];
        if (!in_text || raw < 8'h20 || raw > 8'h7E) begin
            flt = 8'h20;
        end else begin
            flt = raw;
        end
`ifdef LCD_UPCASE_EN
        if (flt >= 8'h61 && flt <= 8'h7A) begin
            chr = flt - 8'h20;
        end else begin
            chr = flt;
        end
`else
        chr = flt;
`endif
    end

    always_comb begin
        wr_byte = 8'h00;
        wr_rs   = 1'b0;
        unique case (state)
            INIT: begin
                unique case (idx[1:0])
                    2'd0: wr_byte = 8'h38;
                    2'd1: wr_byte = 8'h0C;
                    2'd2: wr_byte = 8'h06;
                    default: wr_byte = 8'h01;
                endcase
            end
            ADDR1: wr_byte = 8'h80;
            ADDR2: wr_byte = 8'hC0;
            LINE1, LINE2: begin
                wr_byte = chr;
                wr_rs   = 1'b1;
            end
            default: begin
                wr_byte = 8'h00;
                wr_rs   = 1'b0;
            end
        endcase
    end

    // Clear-display needs the long hold; everything else uses the short one.
    assign hold_len = (LCD_DATA == 8'h01 && !LCD_RS) ? 32'(T_CLR) : 32'(T_CMD);
    assign wr_done  = (phase == WR_HOLD) && (wr_cnt == hold_len - 32'd1);
    assign wr_start = (phase == WR_IDLE) && (state != PWRUP) && (state != IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            phase    <= WR_IDLE;
            wr_cnt   <= '0;
            LCD_DATA <= 8'h00;
            LCD_RS   <= 1'b0;
            LCD_EN   <= 1'b0;
        end else if (wr_start) begin
            LCD_DATA <= wr_byte;
            LCD_RS   <= wr_rs;
            phase    <= WR_SETUP;
            wr_cnt   <= '0;
        end else begin
            unique case (phase)
                WR_SETUP: begin
                    if (wr_cnt == 32'd1) begin
                        phase  <= WR_PULSE;
                        LCD_EN <= 1'b1;
                        wr_cnt <= '0;
                    end else begin
                        wr_cnt <= wr_cnt + 32'd1;
                    end
                end
                WR_PULSE: begin
                    if (wr_cnt == 32'(T_EN - 1)) begin
                        phase  <= WR_HOLD;
                        LCD_EN <= 1'b0;
                        wr_cnt <= '0;
                    end else begin
                        wr_cnt <= wr_cnt + 32'd1;
                    end
                end
                WR_HOLD: begin
                    if (wr_done) begin
                        phase  <= WR_IDLE;
                        wr_cnt <= '0;
                    end else begin
                        wr_cnt <= wr_cnt + 32'd1;
                    end
                end
                default: wr_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= PWRUP;
            idx      <= '0;
            pwr_cnt  <= '0;
            snap_msg <= '0;
            snap_len <= '0;
        end else begin
            unique case (state)
                PWRUP: begin
                    if (pwr_cnt == 32'(T_PWRUP - 1)) begin
                        state <= INIT;
                        idx   <= '0;
                    end else begin
                        pwr_cnt <= pwr_cnt + 32'd1;
                    end
                end
                INIT: begin
                    if (wr_done) begin
                        if (idx == 4'd3) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                IDLE: begin
                    if (pending) begin
                        snap_msg <= message_i;
                        snap_len <= length_i;
                        state    <= ADDR1;
                        idx      <= '0;
                    end
                end
                ADDR1: begin
                    if (wr_done) begin
                        state <= LINE1;
                        idx   <= '0;
                    end
                end
                LINE1: begin
                    if (wr_done) begin
                        if (idx == 4'd15) begin
                            state <= ADDR2;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ADDR2: begin
                    if (wr_done) begin
                        state <= LINE2;
                        idx   <= '0;
                    end
                end
                LINE2: begin
                    if (wr_done) begin
                        if (idx == 4'd15) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= PWRUP;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule
